uart_shift_out: RTL
===================

UART_SHIFT_OUT -- requirements
Module: uart_shift_out

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SHIFT_FREQ, default 1_000_000, target clk_out frequency in Hz.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte buffer depth; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, one-cycle strobe marking in_data valid; fed by UART receiver uart_rx_valid.
REQ-007 SHALL have port in_data, input, 8, received byte; fed by UART receiver uart_data.
REQ-008 SHALL have port data_out, output, 1, serial data to 74HC595 SER.
REQ-009 SHALL have port clk_out, output, 1, shift clock to 74HC595 SRCLK.
REQ-010 SHALL have port latch, output, 1, storage-register strobe to 74HC595 RCLK.
REQ-011 SHALL have port busy, output, 1, high while FIFO is non-empty or FSM is not IDLE.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a byte was dropped.

Function
REQ-013 SHALL derive HALF = CLK_FREQ / (2*SHIFT_FREQ) by integer division, clamped to a minimum of 1; defaults give HALF = 13.
REQ-014 SHALL write in_data into the FIFO on any cycle where in_valid=1 and the FIFO is not full; there is no backpressure.
REQ-015 SHALL drop in_data and set overflow when in_valid=1, the FIFO is full, and no pop occurs in the same cycle.
REQ-016 SHALL accept the push when it coincides with a pop on a full FIFO; occupancy is unchanged and overflow is not set.
REQ-017 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH and use a separate count to distinguish full from empty.
REQ-018 SHALL run an FSM with states IDLE, SETUP, HIGH and LATCH.
REQ-019 IDLE: clk_out=0 and latch=0; if the FIFO is non-empty, pop it into an 8-bit shift register, set bit_cnt=7, clear the timer, and go to SETUP.
REQ-020 SETUP: data_out=sr[7] and clk_out=0 for HALF cycles, then go to HIGH.
REQ-021 HIGH: clk_out=1 for HALF cycles; at expiry, go to LATCH if bit_cnt=0, otherwise shift sr left by one, decrement bit_cnt, and go to SETUP.
REQ-022 LATCH: clk_out=0 and latch=1 for HALF cycles, then go to IDLE.
REQ-023 SHALL shift the byte MSB first, so bit 7 reaches QH of the 595 after 8 clocks.
REQ-024 SHALL spend exactly 17*HALF cycles per byte from leaving IDLE to re-entering IDLE, plus 1 IDLE cycle between consecutive bytes.
REQ-025 SHALL make the first clk_out rise occur HALF+2 cycles after an in_valid cycle, given an empty FIFO and the FSM in IDLE.
REQ-026 SHALL register data_out, clk_out and latch with no combinational path from inputs; data_out changes only while clk_out=0.
REQ-027 SHALL keep overflow at 1 until reset.

Reset
REQ-028 SHALL, on reset=1, asynchronously force data_out=0, clk_out=0, latch=0, busy=0, overflow=0, state=IDLE, FIFO empty, and timer and bit_cnt to 0.
REQ-029 SHALL discard a partially shifted byte on reset mid-operation without asserting latch, so the 595 outputs keep their previous value.
REQ-030 SHALL ignore in_valid in any cycle where reset=1.

Structure
REQ-031 SHALL place the FSM state encoding and the HALF computation helper in a shared package, uart_pkg.
REQ-032 SHALL implement the FIFO as a sub-module byte_fifo (push, pop, full, empty, dout) instantiated once.

Verification
REQ-033 Reset release, then in_valid with 0xA5 -> bits 1,0,1,0,0,1,0,1 on data_out sampled at clk_out rises; one latch pulse of 13 cycles; busy drops 221 cycles after leaving IDLE.
REQ-034 Push 0x01, 0x80, 0xFF on consecutive cycles -> three complete frames in order, with 1 IDLE cycle between them, and overflow=0.
REQ-035 Push 6 bytes back-to-back with FIFO_DEPTH=4 -> first 5 bytes shifted out (one popped immediately, 4 buffered), 6th dropped, overflow=1 from the 6th push onward.
REQ-036 in_valid on the exact cycle IDLE pops a full FIFO -> byte accepted, overflow stays 0.
REQ-037 Assert reset during the 4th HIGH phase -> all outputs 0 asynchronously; no latch pulse; a following byte 0x3C shifts out correctly.
REQ-038 Drive UART receiver to shift-out end to end at 115200 baud with random bytes -> every latched byte equals the sent byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-74HC595 shift-out path: FSM state
// encoding and the shift-clock half-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int BYTE_W = 8;

  // Half period of the shift clock in system clocks, never below one cycle.
  function automatic int calc_half(input int clk_freq, input int shift_freq);
    int h;
    h = clk_freq / (2 * shift_freq);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with wrapping pointers and an occupancy count.
// Read data is presented combinationally so a pop can consume it the same cycle.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_shift_out.sv
// Buffers bytes from a UART receiver and shifts each one MSB first into a
// 74HC595, finishing with a storage-register latch pulse.
module uart_shift_out
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int SHIFT_FREQ = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              data_out,
  output logic              clk_out,
  output logic              latch,
  output logic              busy,
  output logic              overflow
);

  localparam int HALF = calc_half(CLK_FREQ, SHIFT_FREQ);
  localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HALF - 1);

  state_t            state_reg, state_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [BYTE_W-1:0] sr_reg, sr_next;
  logic              data_out_reg, data_out_next;
  logic              clk_out_reg, clk_out_next;
  logic              latch_reg, latch_next;
  logic              overflow_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              timer_expired;

  assign fifo_push = in_valid && (!fifo_full || fifo_pop);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign timer_expired = (timer_reg == TIMER_LAST);

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    sr_next       = sr_reg;
    data_out_next = data_out_reg;
    fifo_pop      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          sr_next       = fifo_dout;
          bit_cnt_next  = 3'd7;
          data_out_next = fifo_dout[BYTE_W-1];
          state_next    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_expired) begin
          timer_next = '0;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (timer_expired) begin
          timer_next = '0;
          if (bit_cnt_reg == 3'd0) begin
            state_next = ST_LATCH;
          end else begin
            // New data bit is presented on the same edge that drops clk_out.
            sr_next       = sr_reg << 1;
            bit_cnt_next  = bit_cnt_reg - 1'b1;
            data_out_next = sr_reg[BYTE_W-2];
            state_next    = ST_SETUP;
          end
        end
      end
      ST_LATCH: begin
        if (timer_expired) begin
          timer_next = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        timer_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    clk_out_next = (state_next == ST_HIGH);
    latch_next   = (state_next == ST_LATCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      data_out_reg <= 1'b0;
      clk_out_reg  <= 1'b0;
      latch_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      data_out_reg <= data_out_next;
      clk_out_reg  <= clk_out_next;
      latch_reg    <= latch_next;
      // Sticky: set only when a byte is genuinely lost.
      if (in_valid && fifo_full && !fifo_pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign data_out = data_out_reg;
  assign clk_out  = clk_out_reg;
  assign latch    = latch_reg;
  assign overflow = overflow_reg;
  assign busy     = !fifo_empty || (state_reg != ST_IDLE);

endmodule
